// File: rtl/stepper_io_ctrl_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// stepper_io_ctrl_pkg : shared state encoding, register fields, JA pin map
// Revision 1.0
// -----------------------------------------------------------------------------
package stepper_io_ctrl_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // r24 command word fields
   localparam int TAG_MSB    = 31;
   localparam int TAG_LSB    = 24;
   localparam int DIR_BIT    = 23;
   // r25 parameter word fields
   localparam int DUTY_MSB   = 31;
   localparam int DUTY_LSB   = 24;
   localparam int PERIOD_MSB = 23;
   localparam int PERIOD_LSB = 0;
   // JA header pin map
   localparam int COIL_LSB   = 0;
   localparam int BUSY_BIT   = 4;
   localparam int PWM_BIT    = 5;

   function automatic logic [3:0] coil_onehot(input logic [1:0] phase);
      return 4'b0001 << phase;
   endfunction

   function automatic logic [23:0] clamp_period(input logic [23:0] req,
                                                input logic [23:0] min_p);
      return (req < min_p) ? min_p : req;
   endfunction

endpackage
`default_nettype wire

// File: rtl/stepper_io_ctrl_pwm_gen.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pwm_gen : 8-bit free-running counter compared against a live duty value
// Revision 1.0
// -----------------------------------------------------------------------------
module pwm_gen (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] duty,
   output logic       pwm
);

   logic [7:0] pwm_cnt_q, pwm_cnt_d;
   logic       pwm_q, pwm_d;

   always_comb begin
      pwm_cnt_d = pwm_cnt_q + 8'd1;
      pwm_d     = (pwm_cnt_q < duty);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pwm_cnt_q <= 8'd0;
         pwm_q     <= 1'b0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
         pwm_q     <= pwm_d;
      end
   end

   assign pwm = pwm_q;

endmodule
`default_nettype wire

// File: rtl/stepper_io_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// stepper_io_ctrl : r24/r25-driven full-step stepper, busy flag and PWM on JA
// Revision 1.0
// -----------------------------------------------------------------------------
module stepper_io_ctrl
   import stepper_io_ctrl_pkg::*;
#(
   parameter logic [23:0] MIN_PERIOD = 24'd1000,
   parameter logic        HOLD_EN    = 1'b0,
   parameter int          CNT_W      = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] reg_24,
   input  logic [31:0] reg_25,
   output logic [5:0]  JA,
   output logic        busy
);

   logic [31:0]      in_24_q, in_25_q;
   logic [7:0]       last_tag_q, last_tag_d;
   state_e           state_q, state_d;
   logic [1:0]       phase_q, phase_d;
   logic             dir_q, dir_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [23:0]      period_q, period_d;
   logic [23:0]      cnt_q, cnt_d;
   logic [3:0]       coil_q, coil_d;
   logic             busy_q, busy_d;
   logic             pwm_out;

   logic [7:0]       cmd_tag;
   logic [CNT_W-1:0] cmd_count;
   logic             new_cmd;
   logic             unused_cmd_bits;

   assign cmd_tag         = in_24_q[TAG_MSB:TAG_LSB];
   assign cmd_count       = in_24_q[CNT_W-1:0];
   assign new_cmd         = (cmd_tag != last_tag_q);
   assign unused_cmd_bits = ^in_24_q[DIR_BIT-1:CNT_W];

   always_comb begin
      state_d     = state_q;
      last_tag_d  = last_tag_q;
      phase_d     = phase_q;
      dir_d       = dir_q;
      remaining_d = remaining_q;
      period_d    = period_q;
      cnt_d       = cnt_q;
      coil_d      = 4'b0000;
      busy_d      = 1'b0;

      // A fresh tag overrides any step due on this edge; phase is never reloaded.
      if (new_cmd) begin
         last_tag_d = cmd_tag;
         if (cmd_count != '0) begin
            state_d     = ST_RUN;
            remaining_d = cmd_count;
            dir_d       = in_24_q[DIR_BIT];
            period_d    = clamp_period(in_25_q[PERIOD_MSB:PERIOD_LSB], MIN_PERIOD);
            cnt_d       = period_d;
         end else begin
            state_d = ST_IDLE;
         end
      end else if (state_q == ST_RUN) begin
         if (cnt_q == 24'd1) begin
            phase_d     = dir_q ? (phase_q - 2'd1) : (phase_q + 2'd1);
            remaining_d = remaining_q - CNT_W'(1);
            cnt_d       = period_q;
            if (remaining_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
            end
         end else begin
            cnt_d = cnt_q - 24'd1;
         end
      end

      busy_d = (state_d == ST_RUN);
      if (busy_d || HOLD_EN) begin
         coil_d = coil_onehot(phase_d);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         in_24_q     <= 32'd0;
         in_25_q     <= 32'd0;
         last_tag_q  <= 8'h00;
         state_q     <= ST_IDLE;
         phase_q     <= 2'd0;
         dir_q       <= 1'b0;
         remaining_q <= '0;
         period_q    <= 24'd0;
         cnt_q       <= 24'd0;
         coil_q      <= 4'b0000;
         busy_q      <= 1'b0;
      end else begin
         in_24_q     <= reg_24;
         in_25_q     <= reg_25;
         last_tag_q  <= last_tag_d;
         state_q     <= state_d;
         phase_q     <= phase_d;
         dir_q       <= dir_d;
         remaining_q <= remaining_d;
         period_q    <= period_d;
         cnt_q       <= cnt_d;
         coil_q      <= coil_d;
         busy_q      <= busy_d;
      end
   end

   pwm_gen u_pwm_gen (
      .clock (clock),
      .reset (reset),
      .duty  (in_25_q[DUTY_MSB:DUTY_LSB]),
      .pwm   (pwm_out)
   );

   assign JA[COIL_LSB +: 4] = coil_q;
   assign JA[BUSY_BIT]      = busy_q;
   assign JA[PWM_BIT]       = pwm_out;
   assign busy              = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_stepper_io_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_stepper_io_ctrl : directed moves checked against a move-level timing model
// Revision 1.0
// -----------------------------------------------------------------------------
module tb_stepper_io_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] reg_24, reg_25;
   logic [5:0]  JA;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;
   bit check_en = 1'b0;

   stepper_io_ctrl #(
      .MIN_PERIOD (24'd1000),
      .HOLD_EN    (1'b0),
      .CNT_W      (16)
   ) dut (
      .clock  (clk),
      .reset  (reset),
      .reg_24 (reg_24),
      .reg_25 (reg_25),
      .JA     (JA),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Move-level model: a move started at edge k0 with N steps of P clocks has
   // made floor((k-k0)/P) steps (capped at N) by edge k and is busy while k-k0 < N*P.
   logic [31:0] m_in24 = 0, m_in25 = 0;
   logic [7:0]  m_last = 0;
   bit          m_run = 0, m_dir = 0;
   longint      m_start = 0, m_n = 0, m_p = 0, k = 0, m_d = 0, m_s = 0;
   int          m_base = 0, m_phase = 0, ph = 0;
   bit          bz = 0;
   logic [3:0]  exp_coil = 0;
   logic        exp_busy = 0, exp_pwm = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_in24 = 0; m_in25 = 0; m_last = 0; m_run = 0; m_phase = 0; k = 0;
         exp_coil = 0; exp_busy = 0; exp_pwm = 0;
      end else begin
         ph = m_phase;
         bz = 0;
         if (m_run) begin
            m_d = k - m_start;
            m_s = m_d / m_p;
            if (m_s > m_n) m_s = m_n;
            ph = (m_base + (m_dir ? (4 - int'(m_s % 4)) : int'(m_s % 4))) % 4;
            bz = (m_d < m_n * m_p);
            if (!bz) m_run = 0;
         end
         if (m_in24[31:24] != m_last) begin
            m_last = m_in24[31:24];
            ph = m_phase;
            if (m_in24[15:0] != 16'd0) begin
               m_run   = 1;
               m_start = k;
               m_n     = longint'(m_in24[15:0]);
               m_p     = (m_in25[23:0] < 24'd1000) ? 1000 : longint'(m_in25[23:0]);
               m_dir   = m_in24[23];
               m_base  = m_phase;
               bz      = 1;
            end else begin
               m_run = 0;
               bz    = 0;
            end
         end
         exp_busy = bz;
         exp_coil = bz ? 4'(1 << ph) : 4'd0;
         exp_pwm  = (k % 256) < longint'(m_in25[31:24]);
         m_phase  = ph;
         m_in24   = reg_24;
         m_in25   = reg_25;
         k++;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         check("cycle_ja", {26'd0, JA}, {26'd0, exp_pwm, exp_busy, exp_coil});
         check("cycle_busy", {31'd0, busy}, {31'd0, exp_busy});
      end
   end

   function automatic logic [31:0] cmd(input logic [7:0] tag, input logic dir, input logic [15:0] cnt);
      return {tag, dir, 7'd0, cnt};
   endfunction

   int highs;

   initial begin
      reg_24 = 0; reg_25 = 0; reset = 1'b1;
      #2 reset = 1'b0;
      repeat (5) begin
         @(negedge clk);
         reg_24 = $urandom;
         reg_25 = $urandom;
      end
      check_en = 1'b1;
      @(negedge clk);
      check("reset_ja", {26'd0, JA}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      reg_24 = 0; reg_25 = 0;
      @(negedge clk);
      reset = 1'b1;
      tick(10);
      check("idle_after_release", {31'd0, busy}, 32'd0);

      // forward 3 steps, P=1000
      reg_25 = 32'h0000_03E8;
      tick(1);
      reg_24 = cmd(8'h01, 1'b0, 16'd3);
      tick(1);
      check("fwd_not_yet_busy", {31'd0, busy}, 32'd0);
      tick(1);
      check("fwd_busy_rise", {31'd0, busy}, 32'd1);
      check("fwd_coil0", {28'd0, JA[3:0]}, 32'h1);
      tick(999);
      check("fwd_coil0_hold", {28'd0, JA[3:0]}, 32'h1);
      tick(1);
      check("fwd_coil1", {28'd0, JA[3:0]}, 32'h2);
      tick(1000);
      check("fwd_coil2", {28'd0, JA[3:0]}, 32'h4);
      tick(999);
      check("fwd_busy_last", {31'd0, busy}, 32'd1);
      tick(1);
      check("fwd_busy_fall", {31'd0, busy}, 32'd0);
      check("fwd_idle_coil", {28'd0, JA[3:0]}, 32'h0);

      // reverse 5 steps from phase 3, wraps 0->3
      reg_24 = cmd(8'h02, 1'b1, 16'd5);
      tick(2);
      check("rev_coil3", {28'd0, JA[3:0]}, 32'h8);
      tick(1000);
      check("rev_coil2", {28'd0, JA[3:0]}, 32'h4);
      tick(3000);
      check("rev_wrap", {28'd0, JA[3:0]}, 32'h8);
      tick(1000);
      check("rev_done", {31'd0, busy}, 32'd0);

      // zero-count command while idle, then clamped period and same-tag rewrite
      reg_24 = cmd(8'h03, 1'b0, 16'd0);
      tick(5);
      check("zero_count_idle", {31'd0, busy}, 32'd0);
      reg_25 = 32'd5;
      reg_24 = cmd(8'h04, 1'b0, 16'd2);
      tick(2);
      check("clamp_start", {28'd0, JA[3:0]}, 32'h4);
      tick(500);
      reg_24 = cmd(8'h04, 1'b1, 16'd7);
      tick(499);
      check("clamp_no_early_step", {28'd0, JA[3:0]}, 32'h4);
      tick(1);
      check("clamp_step", {28'd0, JA[3:0]}, 32'h8);
      tick(999);
      check("same_tag_ignored", {31'd0, busy}, 32'd1);
      tick(1);
      check("clamp_done", {31'd0, busy}, 32'd0);

      // restart mid-move with a new period
      reg_25 = 32'd1000;
      reg_24 = cmd(8'h05, 1'b0, 16'd6);
      tick(2);
      check("restart_pre", {28'd0, JA[3:0]}, 32'h1);
      tick(2500);
      reg_25 = 32'd2000;
      reg_24 = cmd(8'h06, 1'b0, 16'd2);
      tick(2);
      check("restart_phase_kept", {28'd0, JA[3:0]}, 32'h4);
      tick(1999);
      check("restart_no_early", {28'd0, JA[3:0]}, 32'h4);
      tick(1);
      check("restart_step1", {28'd0, JA[3:0]}, 32'h8);
      tick(1999);
      check("restart_busy_last", {31'd0, busy}, 32'd1);
      tick(1);
      check("restart_done", {31'd0, busy}, 32'd0);

      // reset in the middle of a move
      reg_25 = 32'd1000;
      reg_24 = cmd(8'h07, 1'b0, 16'd4);
      tick(502);
      check("pre_reset_busy", {31'd0, busy}, 32'd1);
      #1 reset = 1'b0;
      #1;
      check("async_reset_ja", {26'd0, JA}, 32'd0);
      check("async_reset_busy", {31'd0, busy}, 32'd0);
      tick(3);
      reg_24 = 0;
      tick(1);
      reset = 1'b1;
      tick(5);
      check("post_reset_idle", {31'd0, busy}, 32'd0);

      // PWM duty sweeps
      reg_25 = {8'd64, 24'd1000};
      tick(3);
      highs = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         highs += int'(JA[5]);
      end
      check("pwm_duty64", highs, 32'd64);
      reg_25 = {8'd0, 24'd1000};
      tick(3);
      highs = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         highs += int'(JA[5]);
      end
      check("pwm_duty0", highs, 32'd0);
      reg_25 = {8'd255, 24'd1000};
      tick(3);
      highs = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         highs += int'(JA[5]);
      end
      check("pwm_duty255", highs, 32'd255);

      check_en = 1'b0;
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
